// File: rtl/popcount_word_gen.sv
// ============================================================================
// Module   : popcount_word_gen
// Purpose  : Converts a requested ones-count into a burst of W-bit
//            thermometer words. The ones are packed from bit 0 upward. The
//            total population of the burst equals the requested count.
//            Used to source known-weight vectors for popcount/adder trees.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            cnt_valid/ready - request handshake, cnt_data = ones count
//            word_valid/ready- output word handshake
//            word_data       - thermometer word
//            word_last       - final word of the burst
//            word_ones       - population of word_data (0..W)
//            busy            - burst in progress
//            err             - sticky checker error (0 without checker)
// Config   : define POPCHK_EN to build the optional popcount/total checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_word_gen #(
  parameter int W  = 32,
  parameter int CW = 10,
  parameter int OW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cnt_valid,
  output logic          cnt_ready,
  input  logic [CW-1:0] cnt_data,
  output logic          word_valid,
  input  logic          word_ready,
  output logic [W-1:0]  word_data,
  output logic          word_last,
  output logic [OW-1:0] word_ones,
  output logic          busy,
  output logic          err
);

  localparam int            LW      = $clog2(W);
  localparam logic [CW:0]   c_W_EXT = (CW + 1)'(W);
  localparam logic [CW-1:0] c_W_CW  = CW'(W);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  // Holds cnt_ready low for the first cycle after reset so the handshake
  // output stays purely registered.
  logic          rdy_q;

  logic          w_full;
  logic          w_last;

  assign w_full = ({1'b0, rem_q} >= c_W_EXT);
  assign w_last = ({1'b0, rem_q} <= c_W_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      rdy_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    cnt_ready  = 1'b0;
    word_valid = 1'b0;
    busy       = 1'b0;
    word_data  = '0;
    word_last  = 1'b0;
    word_ones  = '0;
    case (state_q)
      S_IDLE: begin
        cnt_ready = rdy_q;
        if (cnt_valid && rdy_q) begin
          rem_d   = cnt_data;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        word_valid = 1'b1;
        busy       = 1'b1;
        word_last  = w_last;
        if (w_full) begin
          word_data = '1;
          word_ones = OW'(W);
        end else begin
          // rem < W here, so only the low LW bits matter; inverting a
          // left-shifted all-ones mask yields (1 << rem) - 1 in W bits.
          word_data = ~({W{1'b1}} << rem_q[LW-1:0]);
          word_ones = OW'(rem_q[LW-1:0]);
        end
        if (word_ready) begin
          if (w_last) begin
            state_d = S_IDLE;
          end else begin
            // Only reached with rem > W, so no underflow.
            rem_d = rem_q - c_W_CW;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef POPCHK_EN
  function automatic logic [OW-1:0] popcnt(input logic [W-1:0] v);
    logic [OW-1:0] s;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s = s + OW'(v[i]);
    end
    return s;
  endfunction

  logic [CW-1:0] req_q;
  logic [CW:0]   acc_q;
  logic          err_q;
  logic [CW:0]   w_acc_sum;

  assign w_acc_sum = acc_q + (CW + 1)'(word_ones);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= '0;
      acc_q <= '0;
      err_q <= 1'b0;
    end else if (cnt_valid && cnt_ready) begin
      req_q <= cnt_data;
      acc_q <= '0;
    end else if (word_valid && word_ready) begin
      acc_q <= w_acc_sum;
      if (popcnt(word_data) != word_ones) begin
        err_q <= 1'b1;
      end
      if (word_last && (w_acc_sum != {1'b0, req_q})) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_popcount_word_gen.sv
// ============================================================================
// Module   : tb_popcount_word_gen
// Purpose  : Scoreboard bench for popcount_word_gen (W=32, CW=10). Requests
//            push their expected word sequence; a negedge monitor checks
//            every presented word against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_popcount_word_gen;

  localparam int W  = 32;
  localparam int CW = 10;
  localparam int OW = 6;

  typedef struct {
    logic [W-1:0]  d;
    logic          l;
    logic [OW-1:0] o;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          cnt_valid;
  logic          cnt_ready;
  logic [CW-1:0] cnt_data;
  logic          word_valid;
  logic          word_ready;
  logic [W-1:0]  word_data;
  logic          word_last;
  logic [OW-1:0] word_ones;
  logic          busy;
  logic          err;

  exp_t sb[$];
  int   compared;
  int   mismatched;
  bit   mon_en;
  bit   rand_ready;

  popcount_word_gen #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_valid  (cnt_valid),
    .cnt_ready  (cnt_ready),
    .cnt_data   (cnt_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_ones  (word_ones),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: ceil(cnt/W) words (at least one), each carrying
  // min(W, what is still owed) ones packed from bit 0.
  task automatic model_push(input int cnt);
    int   nwords;
    int   ones;
    exp_t e;
    nwords = (cnt == 0) ? 1 : (cnt + W - 1) / W;
    for (int i = 0; i < nwords; i++) begin
      ones = cnt - W * i;
      if (ones > W) ones = W;
      e.d = (ones == W) ? {W{1'b1}} : W'((64'd1 << ones) - 64'd1);
      e.l = (i == nwords - 1);
      e.o = OW'(ones);
      sb.push_back(e);
    end
  endtask

  // Monitor: every valid word must match the queue head, which also
  // proves the word is held steady through a stall.
  always @(negedge clk) begin
    if (mon_en && word_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {32'd0, word_data}, 64'd0);
      end else begin
        chk("word_data", {32'd0, word_data}, {32'd0, sb[0].d});
        chk("word_last", {63'd0, word_last}, {63'd0, sb[0].l});
        chk("word_ones", {58'd0, word_ones}, {58'd0, sb[0].o});
        if (word_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) word_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic accept(input int cnt);
    int n;
    n = 0;
    while (cnt_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (cnt_ready !== 1'b1) begin
      chk("accept_timeout", {63'd0, cnt_ready}, 64'd1);
    end else begin
      cnt_valid = 1'b1;
      cnt_data  = CW'(cnt);
      model_push(cnt);
      tick();
      cnt_valid = 1'b0;
      cnt_data  = CW'($urandom);
    end
  endtask

  // Wait for the scoreboard to empty; exp_cyc >= 0 checks the burst took
  // exactly that many cycles from the first presented word.
  task automatic drain(input int exp_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end else begin
      if (exp_cyc >= 0) chk("burst_cycles", 64'(n), 64'(exp_cyc));
      chk("idle_valid", {63'd0, word_valid}, 64'd0);
      chk("idle_ready", {63'd0, cnt_ready}, 64'd1);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    mon_en     = 1'b0;
    rand_ready = 1'b0;
    rst        = 1'b1;
    cnt_valid  = 1'b0;
    cnt_data   = '0;
    word_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_word_valid", {63'd0, word_valid}, 64'd0);
    chk("rst_word_data", {32'd0, word_data}, 64'd0);
    chk("rst_word_last", {63'd0, word_last}, 64'd0);
    chk("rst_word_ones", {58'd0, word_ones}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_cnt_ready", {63'd0, cnt_ready}, 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();
    chk("post_rst_ready", {63'd0, cnt_ready}, 64'd1);

    // cnt=0: one zero word, ready again two cycles after accept
    accept(0);
    chk("lat0_valid", {63'd0, word_valid}, 64'd1);
    chk("lat0_busy", {63'd0, busy}, 64'd1);
    drain(1);

    // cnt=5: single partial word, one-cycle latency
    accept(5);
    chk("lat5_valid", {63'd0, word_valid}, 64'd1);
    drain(1);

    // cnt=64: exact multiple, no trailing zero word
    accept(64);
    drain(2);

    // cnt=70 with a three-cycle stall on the second word
    accept(70);
    tick();
    word_ready = 1'b0;
    repeat (3) tick();
    chk("stall_busy", {63'd0, busy}, 64'd1);
    word_ready = 1'b1;
    drain(-1);

    // cnt=1023: 32 back-to-back words, then cnt=1 immediately
    accept(1023);
    drain(32);
    accept(1);
    drain(1);

    // reset in the middle of cnt=100
    accept(100);
    tick();
    mon_en = 1'b0;
    rst    = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("abort_valid", {63'd0, word_valid}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_err", {63'd0, err}, 64'd0);
    mon_en = 1'b1;
    accept(3);
    drain(1);

    // randomized requests with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       accept($urandom_range(0, 40));
        1:       accept(W * $urandom_range(0, 31));
        default: accept($urandom_range(0, 1023));
      endcase
      drain(-1);
    end
    rand_ready = 1'b0;
    word_ready = 1'b1;
    tick();
    chk("final_err", {63'd0, err}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/popcount_word_gen.md
# popcount_word_gen

Inverse of the 32-input population counter: accepts a ones-count over a valid/ready handshake and emits a burst of W-bit thermometer-coded words whose total population equals that count. Used to source known-weight test vectors and unary operands for the popcount/adder-tree datapath. A companion popcount checker is optional.

## Interface

**Parameters**
- `W`, default 32: output word width in bits; power of two, ≥ 2.
- `CW`, default 10: width of the requested count.
- `OW`, default clog2(W+1) = 6: width of `word_ones`. Derived; do not override.

**Ports**
- `clk`  in  1: clock.
- `rst`  in  1: reset. Synchronous, active-high.
- `cnt_valid`  in  1: request valid.
- `cnt_ready`  out  1: block can accept a request.
- `cnt_data`  in  CW: requested total number of ones, 0..2^CW−1.
- `word_valid`  out  1: output word valid.
- `word_ready`  in  1: downstream accepts the word.
- `word_data`  out  W: thermometer word. Ones are packed from bit 0 upward.
- `word_last`  out  1: final word of the burst.
- `word_ones`  out  OW: population of `word_data`, 0..W.
- `busy`  out  1: a burst is in progress.
- `err`  out  1: sticky checker error. Tied to 0 when the checker is compiled out.

## Operation

**States.** Two states: IDLE and EMIT. There is a remainder register `rem` (CW bits).

**IDLE**
- `cnt_ready` = 1, `word_valid` = 0, `busy` = 0.
- On `cnt_valid & cnt_ready`:
  - `rem` ← `cnt_data`
  - state ← EMIT

**EMIT**
- `cnt_ready` = 0, `word_valid` = 1, `busy` = 1.
- If `rem` ≥ W:
  - `word_data` = all ones
  - `word_ones` = W
- Otherwise:
  - `word_data` = (1 << `rem`) − 1
  - `word_ones` = `rem`
- `word_last` = (`rem` ≤ W).
- On `word_valid & word_ready`:
  - if `word_last`, state ← IDLE;
  - else `rem` ← `rem` − W.

**Burst length and edge counts**
- Words per burst = max(1, ceil(cnt/W)).
- cnt = 0 produces exactly one all-zero word with `word_last` = 1.
- cnt that is an exact multiple of W ends on a full word with `word_last` = 1. No trailing zero word is emitted.

**Output stability**
- While `word_valid & ~word_ready`, the values of `word_data`, `word_last` and `word_ones` are held unchanged.
- `cnt_data` is sampled only on the accept edge. Later changes to it have no effect on the burst in progress.

**Reset**
- `rst` may be asserted mid-burst. The burst is abandoned and the partial burst is not completed or flushed.
- `rst` clears `err`.

**Arithmetic**
- `rem` − W is computed in CW bits. It never underflows, because subtraction happens only when `rem` > W.

## Timing

- Reset values of all outputs:
  - `word_valid` = 0, `word_data` = 0, `word_last` = 0, `word_ones` = 0, `busy` = 0, `err` = 0.
  - `cnt_ready` = 0 during the `rst` cycle and 1 on the first cycle after it.
- Latency: a request accepted at edge t presents its first word from cycle t+1.
- Throughput: one word per cycle while `word_ready` = 1.
- Inter-burst gap: `cnt_ready` rises the cycle after the last word handshake, giving one idle cycle between bursts.
- `cnt_ready` does not depend combinationally on `cnt_valid`.
- `word_valid` does not depend combinationally on `word_ready`.
- All outputs are decoded from registered state and `rem`. There is no combinational path from inputs to outputs.

## Configuration

The checker is controlled by `POPCHK_EN`.

**With `POPCHK_EN` defined:**
- An internal popcount of `word_data` is compared against `word_ones` on every output handshake.
- A per-burst accumulator sums `word_ones` and is compared against the latched `cnt_data` on the `word_last` handshake.
- Either mismatch sets `err` = 1 on the following cycle. `err` stays set until `rst`.

**Without `POPCHK_EN`:**
- No checker logic is built and `err` is constant 0.
- All other behaviour is identical.

## Test plan

All scenarios use W=32, CW=10.

1. Reset, then cnt=0 → exactly one word `0x00000000`, `word_last`=1, `word_ones`=0; `cnt_ready`=1 two cycles after accept.
2. cnt=5 → one word `0x0000001F`, `word_last`=1, `word_ones`=5, first `word_valid` one cycle after accept.
3. cnt=64 → two words `0xFFFFFFFF`, `word_last` only on the second; no third word.
4. cnt=70, `word_ready` held low 3 cycles on the second word → sequence `0xFFFFFFFF`, `0xFFFFFFFF`, `0x0000003F` (`word_last`, `word_ones`=6); the held word stays unchanged through the stall.
5. cnt=1023 with `word_ready`=1 → 32 consecutive words: 31 words of `0xFFFFFFFF`, then `0x7FFFFFFF` with `word_ones`=31 and `word_last`; back-to-back second request cnt=1 accepted one cycle after the last handshake.
6. cnt=100, `rst` asserted after the first word handshake → next cycle `word_valid`=0, `busy`=0, `err`=0; then `cnt_ready`=1 and a fresh cnt=3 yields `0x00000007`. With `POPCHK_EN`, `err` remains 0 throughout all scenarios.
